tdc_fifo_writer: RTL and testbench

- Downstream consumer of the fake TDC request generator.
- On a `wr_en` request, it captures one 24-bit TDC sample and writes it into the byte-wide output FIFO as three bytes, MSB first.
- It then returns a one-cycle `f_FIFO_writing_done` pulse, which clears the upstream request.
- It handles FIFO backpressure, aborts on a prolonged stall, and counts dropped records.

---
 rtl/tdc_fifo_writer_if.sv | 24 ++
 rtl/tdc_fifo_writer.sv | 76 +++++++
 tb/tb_tdc_fifo_writer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdc_fifo_writer_if.sv
// tdc_fifo_writer_if: request/sample bundle from the TDC plus the byte FIFO write side and status.
interface tdc_fifo_writer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] tdc_data;
    logic                  fifo_full;
    logic [7:0]            fifo_din;
    logic                  fifo_wr;
    logic                  f_FIFO_writing_done;
    logic                  busy;
    logic [7:0]            drop_cnt;
    logic                  frame_err;

    modport master (
        output wr_en, tdc_data, fifo_full,
        input  fifo_din, fifo_wr, f_FIFO_writing_done, busy, drop_cnt, frame_err
    );

    modport slave (
        input  wr_en, tdc_data, fifo_full,
        output fifo_din, fifo_wr, f_FIFO_writing_done, busy, drop_cnt, frame_err
    );
endinterface

// File: rtl/tdc_fifo_writer.sv
// tdc_fifo_writer: serialises one captured TDC sample into the byte FIFO MSB first, with stall abort.
module tdc_fifo_writer #(
    parameter int DATA_WIDTH = 24,
    parameter int N_BYTES    = 3,
    parameter int STALL_MAX  = 255
) (
    input logic              clk,
    input logic              rst,
    tdc_fifo_writer_if.slave bus
);
    localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE, HOLDOFF} state_t;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [15:0]           r_stall;
    logic [DATA_WIDTH-1:0] r_sample;
    logic [7:0]            r_drop;
    logic                  r_ferr;
    logic                  w_last;
    logic                  w_abort;
    logic [7:0]            w_byte;

    assign w_last  = r_idx == IW'(N_BYTES - 1);
    assign w_abort = bus.fifo_full && r_stall == 16'(STALL_MAX - 1);

    // Byte index 0 selects the most significant byte of the sample.
    always_comb begin
        w_byte = '0;
        for (int k = 0; k < N_BYTES; k++)
            if (r_idx == IW'(N_BYTES - 1 - k)) w_byte = r_sample[8*k +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_stall  <= '0;
            r_sample <= '0;
            r_drop   <= '0;
            r_ferr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.wr_en) begin
                    r_sample <= bus.tdc_data;
                    r_idx    <= '0;
                    r_stall  <= '0;
                    r_state  <= WRITE;
                end
                WRITE: if (!bus.fifo_full) begin
                    r_stall <= '0;
                    r_idx   <= w_last ? '0 : r_idx + IW'(1);
                    if (w_last) r_state <= DONE;
                end else if (w_abort) begin
                    r_stall <= '0;
                    r_idx   <= '0;
                    r_drop  <= r_drop + {7'd0, r_drop != 8'hFF};
                    r_ferr  <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_stall <= r_stall + 16'd1;
                end
                DONE:    r_state <= HOLDOFF;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_wr             = r_state == WRITE && !bus.fifo_full;
    assign bus.fifo_din            = r_state == WRITE ? w_byte : 8'h00;
    assign bus.f_FIFO_writing_done = r_state == DONE;
    assign bus.busy                = r_state != IDLE;
    assign bus.drop_cnt            = r_drop;
    assign bus.frame_err           = r_ferr;
endmodule

// File: tb/tb_tdc_fifo_writer.sv
// tb_tdc_fifo_writer: vector table, random records against a latency/byte model, and abort/reset sequences.
module tb_tdc_fifo_writer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdc_fifo_writer_if #(.DATA_WIDTH(24)) ia ();
    tdc_fifo_writer_if #(.DATA_WIDTH(24)) ib ();

    tdc_fifo_writer #(.DATA_WIDTH(24), .N_BYTES(3), .STALL_MAX(255)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    tdc_fifo_writer #(.DATA_WIDTH(24), .N_BYTES(3), .STALL_MAX(4))   dut_b (.clk(clk), .rst(rst), .bus(ib));

    typedef struct {
        logic [23:0] d;
        int          s;
        int          l;
        bit          tog;
        bit          scr;
        bit          early;
        bit          rnd;
        int          exp_done;
    } vec_t;

    int total = 0, bad = 0, cyc = 0, done_a = 0, done_b = 0, wide = 0;
    logic pa = 1'b0, pb = 1'b0;
    logic [7:0] qa[$], qb[$];
    int dca[$];

    // Bus monitor: FIFO writes happen at the edge following a cycle with fifo_wr high.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ia.fifo_wr) qa.push_back(ia.fifo_din);
        if (ib.fifo_wr) qb.push_back(ib.fifo_din);
        if (ia.f_FIFO_writing_done) begin
            done_a <= done_a + 1;
            dca.push_back(cyc);
        end
        if (ib.f_FIFO_writing_done) done_b <= done_b + 1;
        if ((ia.f_FIFO_writing_done && pa) || (ib.f_FIFO_writing_done && pb)) wide <= wide + 1;
        pa <= ia.f_FIFO_writing_done;
        pb <= ib.f_FIFO_writing_done;
    end

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string n, input logic [23:0] d, input logic [7:0] q[$]);
        chk({n, " nbytes"}, q.size(), 3);
        for (int j = 0; j < q.size() && j < 3; j++)
            chk($sformatf("%s byte%0d", n, j), int'(q[j]), int'(d[23-8*j -: 8]));
    endtask

    // Model: done is the cycle after the third cycle in which the FIFO was not full.
    task automatic do_rec(input vec_t v, output int done_at, output int mdl);
        int nf;
        logic f;
        nf = 0;
        done_at = -1;
        mdl = -1;
        ia.tdc_data  = v.d;
        ia.wr_en     = 1'b1;
        ia.fifo_full = 1'b0;
        tick();
        for (int k = 1; k <= 400; k++) begin
            f = v.rnd ? ($urandom_range(3) == 0) : v.tog ? (k % 2 == 1) : (k > v.s && k <= v.s + v.l);
            ia.fifo_full = f;
            if (v.scr) ia.tdc_data = 24'($urandom);
            if (v.early && k >= 2) ia.wr_en = 1'b0;
            if (!f && mdl < 0) begin
                nf++;
                if (nf == 3) mdl = k + 1;
            end
            @(negedge clk);
            if (ia.f_FIFO_writing_done) done_at = k;
            tick();
            if (done_at > 0) break;
        end
        ia.wr_en     = 1'b0;
        ia.fifo_full = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string n, input bit use_mdl);
        int da, md;
        qa.delete();
        do_rec(v, da, md);
        chk({n, " done"}, da, use_mdl ? md : v.exp_done);
        chk_q(n, v.d, qa);
        tick();
    endtask

    task automatic wait_b(input int k0, output int k);
        k = -1;
        for (int c = k0; c < k0 + 600; c++) begin
            @(negedge clk);
            if (ib.f_FIFO_writing_done) begin
                k = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        vec_t tbl[9];
        vec_t v;
        int k, n0, w0;
        tbl[0] = '{24'hA1B2C3, 0, 0,   0, 0, 0, 0, 4};
        tbl[1] = '{24'hA1B2C3, 1, 10,  0, 0, 0, 0, 14};
        tbl[2] = '{24'h000000, 0, 3,   0, 0, 0, 0, 7};
        tbl[3] = '{24'hFFFFFF, 2, 1,   0, 0, 0, 0, 5};
        tbl[4] = '{24'hC0FFEE, 0, 0,   1, 0, 0, 0, 7};
        tbl[5] = '{24'h3C4D5E, 0, 0,   0, 1, 0, 0, 4};
        tbl[6] = '{24'h5A5A5A, 0, 0,   0, 0, 1, 0, 4};
        tbl[7] = '{24'h123456, 0, 254, 0, 0, 0, 0, 258};
        tbl[8] = '{24'h89ABCD, 1, 2,   0, 1, 0, 0, 6};

        rst = 1'b0;
        ia.wr_en = 1'b1; ia.tdc_data = 24'h0F1E2D; ia.fifo_full = 1'b0;
        ib.wr_en = 1'b0; ib.tdc_data = '0;         ib.fifo_full = 1'b0;
        repeat (2) tick();
        chk("rst busy", ia.busy, 0);
        chk("rst wr", ia.fifo_wr, 0);
        chk("rst din", ia.fifo_din, 0);
        chk("rst done", ia.f_FIFO_writing_done, 0);
        chk("rst drop", ia.drop_cnt, 0);
        chk("rst ferr", ia.frame_err, 0);
        chk("rst b busy", ib.busy, 0);

        // wr_en already high when reset releases
        qa.delete();
        rst = 1'b1;
        tick();
        chk("release busy", ia.busy, 1);
        repeat (3) tick();
        chk("release done", ia.f_FIFO_writing_done, 1);
        tick();
        ia.wr_en = 1'b0;
        chk("holdoff busy", ia.busy, 1);
        chk_q("release", 24'h0F1E2D, qa);
        tick();
        chk("idle busy", ia.busy, 0);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i), 1'b0);
        chk("table drop", ia.drop_cnt, 0);

        n0 = 0;
        repeat (30) begin
            if (ia.busy) n0++;
            tick();
        end
        chk("quiet busy", n0, 0);

        // continuous request: a record every 6 cycles
        qa.delete(); dca.delete(); n0 = done_a; w0 = wide;
        ia.tdc_data = 24'h010203; ia.wr_en = 1'b1; ia.fifo_full = 1'b0;
        repeat (61) tick();
        ia.wr_en = 1'b0;
        chk("rearm dones", done_a - n0, 10);
        chk("rearm bytes", qa.size(), 30);
        for (int j = 1; j < dca.size(); j++) chk($sformatf("rearm gap%0d", j), dca[j] - dca[j-1], 6);
        k = 0;
        while (ia.busy && k < 20) begin
            tick();
            k++;
        end
        chk("rearm drain", ia.busy, 0);
        chk("rearm dones end", done_a - n0, 11);
        chk("rearm bytes end", qa.size(), 33);
        for (int j = 0; j < qa.size(); j++) chk($sformatf("rearm b%0d", j), qa[j], j % 3 + 1);
        chk("rearm wide", wide - w0, 0);
        tick();

        // asynchronous reset between byte 1 and byte 2
        qa.delete(); n0 = done_a;
        ia.tdc_data = 24'hDEAD42; ia.wr_en = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst wr", ia.fifo_wr, 0);
        chk("arst busy", ia.busy, 0);
        ia.wr_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk("arst no done", done_a - n0, 0);
        chk("arst bytes", qa.size(), 1);
        v = '{24'h778899, 0, 0, 0, 0, 0, 0, 4};
        run_vec(v, "post arst", 1'b0);

        for (int r = 0; r < 40; r++) begin
            v = '{24'($urandom), 0, 0, 0, 0, 0, 1, 0};
            repeat ($urandom_range(2)) tick();
            run_vec(v, $sformatf("rnd%0d", r), 1'b1);
        end
        chk("rnd drop", ia.drop_cnt, 0);
        chk("rnd ferr", ia.frame_err, 0);
        chk("rnd wide", wide, 0);

        // STALL_MAX=4: three stalls survive, four abort
        qb.delete();
        ib.tdc_data = 24'h102030; ib.wr_en = 1'b1; ib.fifo_full = 1'b1;
        tick();
        repeat (3) tick();
        ib.fifo_full = 1'b0;
        wait_b(4, k);
        chk("b stall3 done", k, 7);
        tick();
        ib.wr_en = 1'b0;
        tick();
        chk_q("b stall3", 24'h102030, qb);
        chk("b stall3 drop", ib.drop_cnt, 0);

        qb.delete(); n0 = done_b;
        ib.tdc_data = 24'hA1B2C3; ib.wr_en = 1'b1; ib.fifo_full = 1'b0;
        tick();
        tick();
        ib.fifo_full = 1'b1;
        wait_b(2, k);
        chk("b abort done", k, 6);
        tick();
        ib.wr_en = 1'b0;
        tick();
        chk("b abort nbytes", qb.size(), 1);
        if (qb.size() > 0) chk("b abort byte", qb[0], 8'hA1);
        chk("b abort drop", ib.drop_cnt, 1);
        chk("b abort ferr", ib.frame_err, 1);

        for (int r = 1; r < 300; r++) begin
            ib.wr_en = 1'b1; ib.fifo_full = 1'b1;
            tick();
            wait_b(1, k);
            if (r == 1) chk("sat latency", k, 5);
            tick();
            ib.wr_en = 1'b0;
            tick();
            if (r == 253) chk("sat 254", ib.drop_cnt, 254);
            if (r == 254) chk("sat 255", ib.drop_cnt, 255);
        end
        chk("sat final", ib.drop_cnt, 255);
        chk("sat ferr", ib.frame_err, 1);
        chk("sat dones", done_b - n0, 300);
        chk("sat nbytes", qb.size(), 1);
        chk("a untouched", ia.drop_cnt, 0);
        chk("wide total", wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
